draw_background_region: RTL and testbench

Parametrised successor to the full-screen background drawer. It redraws either the whole screen or a clipped rectangular sub-region from one of NUM_IMAGES background ROMs. It emits (x, y, colour, plot) in raster order to the VGA write path. ROM read latency is compensated internally, so every plot beat carries its matching colour. It sits between the game control FSM (start/done handshake) and the VGA adapter mux, and is used to erase sprites by restoring only the background under them.

---
 rtl/draw_background_region.sv | 200 ++++++++++++++++++++
 tb/tb_draw_background_region.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_background_region.sv
// Redraws the full screen or a clipped rectangle of one background ROM image,
// streaming (x, y, colour, plot) in raster order with ROM latency compensated.
module draw_background_region #(
   parameter int X_SCREEN_PIXELS = 160,
   parameter int Y_SCREEN_PIXELS = 120,
   parameter int X_W             = 8,
   parameter int Y_W             = 7,
   parameter int COLOUR_W        = 3,
   parameter int NUM_IMAGES      = 5,
   parameter int SEL_W           = 3,
   parameter int ADDR_W          = 15,
   parameter int ROM_LATENCY     = 1
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic                           start,
   input  logic [X_W-1:0]                 regionX0,
   input  logic [Y_W-1:0]                 regionY0,
   input  logic [X_W-1:0]                 regionW,
   input  logic [Y_W-1:0]                 regionH,
   input  logic [SEL_W-1:0]               imageSel,
   output logic [ADDR_W-1:0]              romAddress,
   input  logic [NUM_IMAGES*COLOUR_W-1:0] romData,
   output logic [X_W-1:0]                 plotX,
   output logic [Y_W-1:0]                 plotY,
   output logic [COLOUR_W-1:0]            plotColour,
   output logic                           plot,
   output logic                           busy,
   output logic                           done,
   output logic [1:0]                     dbg_state
);

   localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
   localparam logic [X_W:0] X_MAX = (X_W+1)'(X_SCREEN_PIXELS - 1);
   localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(Y_SCREEN_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_e;

   state_e                state_q, state_d;
   logic [X_W-1:0]        x_q, x_d, x0_q, x0_d, x_end_q, x_end_d;
   logic [Y_W-1:0]        y_q, y_d, y_end_q, y_end_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
   logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
   logic [ROM_LATENCY-1:0] vld_q, vld_d;
   logic [X_W-1:0]        px_q [ROM_LATENCY];
   logic [X_W-1:0]        px_d [ROM_LATENCY];
   logic [Y_W-1:0]        py_q [ROM_LATENCY];
   logic [Y_W-1:0]        py_d [ROM_LATENCY];
   logic                  plot_q, plot_d, busy_q, busy_d, done_q, done_d;
   logic [X_W-1:0]        plot_x_q, plot_x_d;
   logic [Y_W-1:0]        plot_y_q, plot_y_d;
   logic [COLOUR_W-1:0]   colour_q, colour_d;

   // Sums are one bit wider than the operands so X0+W-1 can never wrap.
   logic [X_W:0]   x_sum;
   logic [Y_W:0]   y_sum;
   logic [X_W-1:0] x_lim;
   logic [Y_W-1:0] y_lim;
   logic           empty;

   assign x_sum = {1'b0, regionX0} + {1'b0, regionW} - (X_W+1)'(1);
   assign y_sum = {1'b0, regionY0} + {1'b0, regionH} - (Y_W+1)'(1);
   assign x_lim = (x_sum > X_MAX) ? X_MAX[X_W-1:0] : x_sum[X_W-1:0];
   assign y_lim = (y_sum > Y_MAX) ? Y_MAX[Y_W-1:0] : y_sum[Y_W-1:0];
   assign empty = (regionW == '0) || (regionH == '0) ||
                  ({1'b0, regionX0} > X_MAX) || ({1'b0, regionY0} > Y_MAX);

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [Y_W-1:0] yy,
                                                  input logic [X_W-1:0] xx);
      return ADDR_W'(yy) * ADDR_W'(X_SCREEN_PIXELS) + ADDR_W'(xx);
   endfunction

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      x0_d        = x0_q;
      x_end_d     = x_end_q;
      y_end_d     = y_end_q;
      sel_d       = sel_q;
      flush_cnt_d = flush_cnt_q;
      rom_addr_d  = rom_addr_q;

      // Delay line: a pixel issued now meets its ROM data ROM_LATENCY cycles later.
      vld_d[0] = (state_q == SCAN);
      px_d[0]  = x_q;
      py_d[0]  = y_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         px_d[i]  = px_q[i-1];
         py_d[i]  = py_q[i-1];
      end

      plot_d   = vld_q[ROM_LATENCY-1];
      plot_x_d = px_q[ROM_LATENCY-1];
      plot_y_d = py_q[ROM_LATENCY-1];
      colour_d = '0;
      for (int i = 0; i < NUM_IMAGES; i++) begin
         if (sel_q == SEL_W'(i)) colour_d = romData[i*COLOUR_W +: COLOUR_W];
      end
      busy_d = (state_q == SCAN) || (state_q == FLUSH);
      done_d = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d    = regionX0;
               x_end_d = x_lim;
               y_end_d = y_lim;
               sel_d   = imageSel;
               if (empty) begin
                  state_d = DONE;
               end else begin
                  state_d    = SCAN;
                  x_d        = regionX0;
                  y_d        = regionY0;
                  rom_addr_d = pix_addr(regionY0, regionX0);
               end
            end
         end
         SCAN: begin
            if (x_q == x_end_q) begin
               if (y_q == y_end_q) begin
                  state_d     = FLUSH;
                  flush_cnt_d = '0;
               end else begin
                  x_d = x0_q;
                  y_d = y_q + Y_W'(1);
               end
            end else begin
               x_d = x_q + X_W'(1);
            end
            rom_addr_d = pix_addr(y_d, x_d);
         end
         FLUSH: begin
            if (flush_cnt_q == CNT_W'(ROM_LATENCY - 1)) state_d = DONE;
            else flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         x0_q        <= '0;
         x_end_q     <= '0;
         y_end_q     <= '0;
         sel_q       <= '0;
         flush_cnt_q <= '0;
         rom_addr_q  <= '0;
         vld_q       <= '0;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            px_q[i] <= '0;
            py_q[i] <= '0;
         end
         plot_q   <= 1'b0;
         plot_x_q <= '0;
         plot_y_q <= '0;
         colour_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         x0_q        <= x0_d;
         x_end_q     <= x_end_d;
         y_end_q     <= y_end_d;
         sel_q       <= sel_d;
         flush_cnt_q <= flush_cnt_d;
         rom_addr_q  <= rom_addr_d;
         vld_q       <= vld_d;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            px_q[i] <= px_d[i];
            py_q[i] <= py_d[i];
         end
         plot_q   <= plot_d;
         plot_x_q <= plot_x_d;
         plot_y_q <= plot_y_d;
         colour_q <= colour_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign romAddress = rom_addr_q;
   assign plotX      = plot_x_q;
   assign plotY      = plot_y_q;
   assign plotColour = colour_q;
   assign plot       = plot_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_draw_background_region.sv
// Directed bench for draw_background_region: two instances (ROM latency 1 and 2)
// fed by behavioural ROMs; every plot beat is checked against an expected queue.
module tb_draw_background_region;

   localparam int XW = 8, YW = 7, CW = 3, NI = 5, SW = 3, AW = 15;

   logic clk, rst_n;
   logic start1, start2;
   logic [XW-1:0] rx0, rw;
   logic [YW-1:0] ry0, rh;
   logic [SW-1:0] sel;
   logic [AW-1:0] addr1, addr2;
   logic [NI*CW-1:0] rom1, rom2, rom2a;
   logic [XW-1:0] px1, px2;
   logic [YW-1:0] py1, py2;
   logic [CW-1:0] pc1, pc2;
   logic plot1, plot2, busy1, busy2, done1, done2;
   logic [1:0] st1, st2;

   int cyc;
   int n_checks, n_fail;
   int beat_cnt[2], first_cyc[2], last_cyc[2], busy_cnt[2], done_cnt[2], k_cyc[2];
   logic [XW+YW+CW-1:0] exp_q0[$];
   logic [XW+YW+CW-1:0] exp_q1[$];

   draw_background_region #(.ROM_LATENCY(1)) dut1 (
      .Clock(clk), .Reset(rst_n), .start(start1),
      .regionX0(rx0), .regionY0(ry0), .regionW(rw), .regionH(rh), .imageSel(sel),
      .romAddress(addr1), .romData(rom1),
      .plotX(px1), .plotY(py1), .plotColour(pc1), .plot(plot1),
      .busy(busy1), .done(done1), .dbg_state(st1)
   );

   draw_background_region #(.ROM_LATENCY(2)) dut2 (
      .Clock(clk), .Reset(rst_n), .start(start2),
      .regionX0(rx0), .regionY0(ry0), .regionW(rw), .regionH(rh), .imageSel(sel),
      .romAddress(addr2), .romData(rom2),
      .plotX(px2), .plotY(py2), .plotColour(pc2), .plot(plot2),
      .busy(busy2), .done(done2), .dbg_state(st2)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [CW-1:0] rom_val(input int img, input int a);
      int v;
      v = (a ^ (a >> 3)) + img * 5 + 1;
      return v[CW-1:0];
   endfunction

   function automatic logic [NI*CW-1:0] rom_word(input logic [AW-1:0] a);
      logic [NI*CW-1:0] w;
      for (int i = 0; i < NI; i++) w[i*CW +: CW] = rom_val(i, int'(a));
      return w;
   endfunction

   // Behavioural ROMs: one and two cycles of address-to-data latency
   always @(posedge clk) begin
      rom1  <= rom_word(addr1);
      rom2a <= rom_word(addr2);
      rom2  <= rom2a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (plot1 === 1'b1) begin
         beat_cnt[0]++;
         if (first_cyc[0] < 0) first_cyc[0] = cyc;
         last_cyc[0] = cyc;
         check("beat0_expected", 32'(exp_q0.size() > 0), 1);
         if (exp_q0.size() > 0) check("beat0", 32'({px1, py1, pc1}), 32'(exp_q0.pop_front()));
      end
      if (plot2 === 1'b1) begin
         beat_cnt[1]++;
         if (first_cyc[1] < 0) first_cyc[1] = cyc;
         last_cyc[1] = cyc;
         check("beat1_expected", 32'(exp_q1.size() > 0), 1);
         if (exp_q1.size() > 0) check("beat1", 32'({px2, py2, pc2}), 32'(exp_q1.pop_front()));
      end
      if (busy1 === 1'b1) busy_cnt[0]++;
      if (busy2 === 1'b1) busy_cnt[1]++;
      if (done1 === 1'b1) done_cnt[0]++;
      if (done2 === 1'b1) done_cnt[1]++;
   end

   task automatic push_exp(input int d, input int x0, input int y0, input int w, input int h,
                           input int s);
      int xe, ye;
      logic [CW-1:0] c;
      logic [XW-1:0] xb;
      logic [YW-1:0] yb;
      if (w == 0 || h == 0 || x0 >= 160 || y0 >= 120) return;
      xe = (x0 + w - 1 > 159) ? 159 : x0 + w - 1;
      ye = (y0 + h - 1 > 119) ? 119 : y0 + h - 1;
      for (int y = y0; y <= ye; y++) begin
         for (int x = x0; x <= xe; x++) begin
            c  = (s < NI) ? rom_val(s, y * 160 + x) : '0;
            xb = XW'(x);
            yb = YW'(y);
            if (d == 0) exp_q0.push_back({xb, yb, c});
            else exp_q1.push_back({xb, yb, c});
         end
      end
   endtask

   // Driver: present a region and pulse start for one edge
   task automatic launch(input int d, input int x0, input int y0, input int w, input int h,
                         input int s);
      @(negedge clk);
      beat_cnt[d] = 0; first_cyc[d] = -1; last_cyc[d] = -1;
      busy_cnt[d] = 0; done_cnt[d] = 0;
      push_exp(d, x0, y0, w, h, s);
      rx0 = XW'(x0); ry0 = YW'(y0); rw = XW'(w); rh = YW'(h); sel = SW'(s);
      if (d == 0) start1 = 1'b1;
      else start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      k_cyc[d] = cyc;
   endtask

   task automatic wait_done(input int d, input int n, input int lat);
      int got, dcyc, k;
      got = 0; dcyc = -1; k = k_cyc[d];
      for (int i = 0; i < n + lat + 20 && got == 0; i++) begin
         @(negedge clk);
         if ((d == 0 && done1 === 1'b1) || (d == 1 && done2 === 1'b1)) begin
            got = 1;
            dcyc = cyc;
         end
      end
      repeat (4) @(negedge clk);
      check("done_seen", got, 1);
      check("done_cycle", dcyc, (n == 0) ? k + 1 : k + n + lat + 1);
      check("beat_count", beat_cnt[d], n);
      if (n > 0) begin
         check("first_beat_cycle", first_cyc[d], k + 1 + lat);
         check("last_beat_cycle", last_cyc[d], k + n + lat);
      end
      check("busy_cycles", busy_cnt[d], (n == 0) ? 0 : n + lat);
      check("done_pulses", done_cnt[d], 1);
      check("exp_left", (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
      rx0 = '0; ry0 = '0; rw = '0; rh = '0; sel = '0;
      for (int i = 0; i < 2; i++) begin
         beat_cnt[i] = 0; first_cyc[i] = -1; last_cyc[i] = -1;
         busy_cnt[i] = 0; done_cnt[i] = 0; k_cyc[i] = 0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_plot", plot1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_x", px1, 0);
      check("rst_y", py1, 0);
      check("rst_colour", pc1, 0);
      check("rst_addr", addr1, 0);
      check("rst_state", st1, 0);
      check("rst_plot2", plot2, 0);
      check("rst_addr2", addr2, 0);
      rst_n = 1'b1;

      // Full screen, image 2
      launch(0, 0, 0, 160, 120, 2);
      wait_done(0, 19200, 1);

      // Clipped bottom-right corner
      launch(0, 150, 110, 20, 20, 0);
      wait_done(0, 100, 1);

      // Empty regions: zero width, then X0 off screen
      launch(0, 5, 5, 0, 10, 1);
      wait_done(0, 0, 1);
      launch(1, 160, 0, 4, 4, 1);
      wait_done(1, 0, 2);

      // Latency-2 instance, small region
      launch(1, 10, 5, 3, 2, 1);
      wait_done(1, 6, 2);

      // Out-of-range image select plots black
      launch(1, 0, 0, 4, 2, 6);
      wait_done(1, 8, 2);

      // New start and changed inputs mid-scan are ignored
      launch(0, 20, 30, 10, 4, 1);
      repeat (10) @(negedge clk);
      check("busy_mid", busy1, 1);
      rx0 = '0; ry0 = '0; rw = 8'd5; rh = 7'd5; sel = 3'd3;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done(0, 40, 1);

      // Asynchronous reset during a full-screen scan
      launch(0, 0, 0, 160, 120, 2);
      repeat (300) @(negedge clk);
      check("busy_before_abort", busy1, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_plot", plot1, 0);
      check("abort_busy", busy1, 0);
      check("abort_done", done1, 0);
      check("abort_addr", addr1, 0);
      exp_q0.delete();
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt[0], 0);
      #2 rst_n = 1'b1;

      // Complete redraw after the abort
      launch(0, 0, 0, 160, 120, 4);
      wait_done(0, 19200, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
